divconv_seq: RTL and testbench

Self-sequenced Goldschmidt divider computing Q ≈ X/D by repeated multiplication of numerator and denominator with R = 2 − D. It is the parametrised successor of the hand-sequenced divconv datapath. The external per-cycle mux and load control is replaced by an internal FSM with a start/done handshake. WIDTH and iteration count are configurable, and an optional reciprocal seed table is available. It sits as a multicycle arithmetic unit behind any controller that presents a normalised divisor.

---
 rtl/divconv_pkg.sv | 42 ++++
 rtl/divconv_mul.sv | 27 ++
 rtl/divconv_seq.sv | 158 +++++++++++++++
 tb/tb_divconv_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divconv_pkg.sv
// ============================================================================
// Module      : divconv_pkg
// Description : Shared types and helpers for the divconv_seq Goldschmidt
//               divider: FSM state encoding, fixed-point product truncation
//               and reciprocal seed table entry generation.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package divconv_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RCALC = 3'd1,
        ST_MULD  = 3'd2,
        ST_MULX  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Keep bits [2w-2 : w-1] of a 1.(w-1) x 1.(w-1) product, i.e. rescale the
    // 2.(2w-2) product back to 1.(w-1). Plain truncation, no rounding.
    function automatic logic [63:0] fx_trunc(input logic [63:0] prod, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (prod >> (width - 1)) & mask;
    endfunction

    // Seed entry idx = trunc(2^(w-1) / (1 + (idx+0.5)/2^s)), rewritten in
    // integers as 2^(w+s) / (2^(s+1) + 2*idx + 1). Evaluated at elaboration.
    function automatic logic [63:0] seed_entry(input int width, input int seed_bits,
                                               input int idx);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'd1 << (width + seed_bits);
        den = (64'd1 << (seed_bits + 1)) + 64'(2 * idx + 1);
        return num / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divconv_mul.sv
// ============================================================================
// Module      : divconv_mul
// Description : Combinational WIDTH x WIDTH unsigned fixed-point multiplier
//               returning the truncated 1.(WIDTH-1) result.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module divconv_mul #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_q
);

    import divconv_pkg::*;

    logic [63:0] w_prod;

    // Full-precision product held in 64 bits so every legal WIDTH fits.
    assign w_prod = 64'(i_a) * 64'(i_b);
    assign o_q    = WIDTH'(fx_trunc(w_prod, WIDTH));

endmodule

`default_nettype wire

// File: rtl/divconv_seq.sv
// ============================================================================
// Module      : divconv_seq
// Description : Self-sequenced Goldschmidt divider, Q ~= X/D, using repeated
//               multiplication by R = 2 - D with a start/done handshake.
//               Optional macro DIVCONV_SEED_EN replaces the first R with a
//               reciprocal seed looked up from the divisor's leading bits.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module divconv_seq #(
    parameter int WIDTH     = 8,
    parameter int ITER      = 3,
    parameter int SEED_BITS = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] X,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] rega_out,
    output logic [WIDTH-1:0] regb_out,
    output logic [WIDTH-1:0] regc_out
);

    import divconv_pkg::*;

    localparam int c_CNT_W = 4;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_rega;
    logic [WIDTH-1:0]   r_regb;
    logic [WIDTH-1:0]   r_regc;
    logic [WIDTH-1:0]   r_q;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_last_iter;
    logic [WIDTH-1:0]   w_two_minus;
    logic [WIDTH-1:0]   w_regc_next;
    logic [WIDTH-1:0]   w_mul_a;
    logic [WIDTH-1:0]   w_mul_q;

    assign w_last_iter = (r_cnt == c_CNT_W'(ITER - 1));

    // Two's complement of a 1.(WIDTH-1) value is exactly 2 - D_i.
    assign w_two_minus = ~r_regb + WIDTH'(1);

`ifdef DIVCONV_SEED_EN
    logic [WIDTH-1:0] w_seed_tab [0:(1 << SEED_BITS) - 1];

    generate
        for (genvar gi = 0; gi < (1 << SEED_BITS); gi++) begin : g_seed
            localparam logic [63:0] c_ENTRY = seed_entry(WIDTH, SEED_BITS, gi);
            assign w_seed_tab[gi] = WIDTH'(c_ENTRY);
        end
    endgenerate

    // regb still holds the original divisor during the first RCALC.
    assign w_regc_next = (r_cnt == '0) ? w_seed_tab[r_regb[WIDTH-2 -: SEED_BITS]]
                                       : w_two_minus;
`else
    logic [31:0] w_unused_seed_bits;
    assign w_unused_seed_bits = SEED_BITS;
    assign w_regc_next        = w_two_minus;
`endif

    // One shared multiplier: MULD scales the divisor, every other state the dividend.
    assign w_mul_a = (r_state == ST_MULD) ? r_regb : r_rega;

    divconv_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_a (w_mul_a),
        .i_b (r_regc),
        .o_q (w_mul_q)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DONE accepts a new request just like IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = D[WIDTH-1] ? ST_RCALC : ST_DONE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RCALC: w_next_state = ST_MULD;
            ST_MULD:  w_next_state = ST_MULX;
            ST_MULX:  w_next_state = w_last_iter ? ST_DONE : ST_RCALC;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Datapath registers: operand capture, R update, D and X scaling, result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rega <= '0;
            r_regb <= '0;
            r_regc <= '0;
            r_q    <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_rega <= X;
                        r_regb <= D;
                        r_cnt  <= '0;
                        if (!D[WIDTH-1]) begin
                            r_q   <= '1;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RCALC: r_regc <= w_regc_next;
                ST_MULD:  r_regb <= w_mul_q;
                ST_MULX: begin
                    r_rega <= w_mul_q;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (w_last_iter) begin
                        r_q   <= w_mul_q;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign Q        = r_q;
    assign rega_out = r_rega;
    assign regb_out = r_regb;
    assign regc_out = r_regc;

endmodule

`default_nettype wire

// File: tb/tb_divconv_seq.sv
// ============================================================================
// Module      : tb_divconv_seq
// Description : Self-checking bench for divconv_seq (WIDTH=8, ITER=3,
//               SEED_BITS=3). Seed-table expectations follow DIVCONV_SEED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divconv_seq;

    localparam int c_W    = 8;
    localparam int c_ITER = 3;
    localparam int c_SB   = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d_in  = 8'h00;
    logic [7:0] x_in  = 8'h00;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] q;
    logic [7:0] rega_o;
    logic [7:0] regb_o;
    logic [7:0] regc_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic       m_err  = 1'b0;
    logic [7:0] m_q    = 8'h00;
    logic [7:0] m_pq   = 8'h00;

    divconv_seq #(
        .WIDTH     (c_W),
        .ITER      (c_ITER),
        .SEED_BITS (c_SB)
    ) u_dut (
        .Clk      (clk),
        .Reset    (rst),
        .start    (start),
        .D        (d_in),
        .X        (x_in),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .Q        (q),
        .rega_out (rega_o),
        .regb_out (regb_o),
        .regc_out (regc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quotient from the iteration rules in plain integer fixed point (scale 128).
    function automatic logic [7:0] model_q(input int d, input int x);
        int dd = d;
        int xx = x;
        int r;
        for (int i = 0; i < c_ITER; i++) begin
            r = (256 - dd) % 256;
`ifdef DIVCONV_SEED_EN
            if (i == 0) r = (1 << (c_W + c_SB)) / ((1 << (c_SB + 1)) + 2 * ((d >> 4) % 8) + 1);
`endif
            dd = ((dd * r) / 128) % 256;
            xx = ((xx * r) / 128) % 256;
        end
        return 8'(xx);
    endfunction

    // Transaction-level model: a request costs 3*ITER edges, or finishes at once if unnormalised.
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = 8'h00;
            m_err  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) begin
                m_q   = m_pq;
                m_err = 1'b0;
            end
        end else if (start) begin
            if (!d_in[7]) begin
                m_done = 1'b1;
                m_q    = 8'hFF;
                m_err  = 1'b1;
            end else begin
                m_left = 3 * c_ITER;
                m_pq   = model_q(int'(d_in), int'(x_in));
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, (m_left == 0));
            chk("done", done, m_done);
            chk("Q", q, m_q);
            if (m_done) chk("err", err, m_err);
        end
    end

    task automatic apply(input logic [7:0] d, input logic [7:0] x);
        start = 1'b1;
        d_in  = d;
        x_in  = x;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " done_within_budget"}, done, 1'b1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " ready"}, ready, 1'b1);
        chk({name, " done"}, done, 1'b0);
        chk({name, " err"}, err, 1'b0);
        chk({name, " Q"}, q, 8'h00);
        chk({name, " rega"}, rega_o, 8'h00);
        chk({name, " regb"}, regb_o, 8'h00);
        chk({name, " regc"}, regc_o, 8'h00);
    endtask

    logic [7:0] vec_d [0:6] = '{8'hFF, 8'h81, 8'hA0, 8'hE0, 8'h00, 8'hFF, 8'h90};
    logic [7:0] vec_x [0:6] = '{8'hFF, 8'h01, 8'h00, 8'h7F, 8'h55, 8'h80, 8'hFE};

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1.5 into 1.25, with the intermediate register trail
        apply(8'hC0, 8'hA0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
`ifndef DIVCONV_SEED_EN
            if (k == 1) chk("regc iter1", regc_o, 8'h40);
            if (k == 4) chk("regc iter2", regc_o, 8'hA0);
            if (k == 7) chk("regc iter3", regc_o, 8'h88);
            if (k == 8) chk("regb final", regb_o, 8'h7F);
`else
            if (k == 1) chk("regc seed", regc_o, 8'h51);
`endif
            if (k < 9) chk("done early", done, 1'b0);
        end
        chk("done at N+10", done, 1'b1);
        chk("err normal", err, 1'b0);
`ifndef DIVCONV_SEED_EN
        chk("Q c0/a0", q, 8'h6A);
`else
        chk("Q c0/a0 within 1 lsb", (q >= 8'h69 && q <= 8'h6B), 1'b1);
`endif
        @(negedge clk);

        // Unity divisor
        apply(8'h80, 8'h80);
        wait_done("unity");
`ifndef DIVCONV_SEED_EN
        chk("Q 80/80", q, 8'h80);
`endif
        @(negedge clk);

        // Unnormalised divisor, then a normal request straight from DONE
        apply(8'h40, 8'hA0);
        chk("unnorm done", done, 1'b1);
        chk("unnorm err", err, 1'b1);
        chk("unnorm Q", q, 8'hFF);
        apply(8'hC0, 8'hA0);
        wait_done("after unnorm");
        chk("after unnorm err", err, 1'b0);
        chk("after unnorm Q", q, 8'h6A);
        @(negedge clk);

        // Reset while in MULD of the first iteration
        apply(8'hC0, 8'hA0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("mid reset");
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no done after abort", done, 1'b0);
        end
        apply(8'hC0, 8'hA0);
        wait_done("post reset");
        chk("post reset Q", q, 8'h6A);
        @(negedge clk);

        // Back-to-back with start held high; operand changes while busy are ignored
        start = 1'b1;
        d_in  = 8'hC0;
        x_in  = 8'hA0;
        @(negedge clk);
        d_in = 8'h80;
        x_in = 8'hC0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 9) begin
                chk("b2b first done", done, 1'b1);
                chk("b2b first Q", q, 8'h6A);
            end
            if (k == 10) begin
                chk("b2b no idle gap ready", ready, 1'b0);
                chk("b2b no idle gap done", done, 1'b0);
                start = 1'b0;
            end
        end
        chk("b2b second done", done, 1'b1);
        chk("b2b second Q", q, 8'hC0);
        @(negedge clk);

        // Further vectors checked by the model only
        for (int i = 0; i < 7; i++) begin
            apply(vec_d[i], vec_x[i]);
            wait_done("vector");
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule

`default_nettype wire
